spi_ring_buffer: RTL and testbench

- Parametrised circular FIFO between a processing unit and the SPI transmitter: the producer pushes words, the SPI side pops them.
- Supersedes the linear fill-then-drain buffer with:
  - true wrap-around pointers, so writes and reads interleave freely;
  - an occupancy count output;
  - sticky overflow and underflow error flags;
  - a synchronous flush.
- Any BUF_SIZE ≥ 2 is supported, not only powers of two.

---
 rtl/spi_ring_buffer.sv | 108 ++++++++++
 tb/tb_spi_ring_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_ring_buffer.sv
// spi_ring_buffer: wrap-around word FIFO feeding the SPI transmitter.
// Optional macro SPI_RING_BUFFER_OVERWRITE_EN: a push while full overwrites the oldest word.
module spi_ring_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_SIZE   = 10,
   parameter int ATTR_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          oe,
   output logic [DATA_WIDTH-1:0]         data_out,
   input  logic                          flush,
   input  logic                          clr_err,
   output logic [$clog2(BUF_SIZE+1)-1:0] count,
   output logic [ATTR_WIDTH-1:0]         attr_out
);

   localparam int PW = $clog2(BUF_SIZE);
   localparam int CW = $clog2(BUF_SIZE+1);

   logic [DATA_WIDTH-1:0] mem [BUF_SIZE];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         cnt_n;
   logic                  empty_q;
   logic                  full_q;
   logic                  ovf_q;
   logic                  udf_q;

   logic do_pop;
   logic push_ok;
   logic ovf_ev;
   logic udf_ev;
   logic ow;

   // Non-power-of-two depths need an explicit wrap compare.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_SIZE-1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      do_pop  = oe & ~empty_q;
      udf_ev  = oe & empty_q & ~flush;
      push_ok = wr & ~flush & (~full_q | do_pop);
      ovf_ev  = wr & ~flush & full_q & ~do_pop;
`ifdef SPI_RING_BUFFER_OVERWRITE_EN
      ow      = ovf_ev;
`else
      ow      = 1'b0;
`endif
   end

   always_comb begin
      cnt_n = count_q;
      if (flush) begin
         cnt_n = '0;
      end else begin
         unique case ({push_ok, do_pop})
            2'b10:   cnt_n = count_q + CW'(1);
            2'b01:   cnt_n = count_q - CW'(1);
            default: cnt_n = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok | ow) wr_ptr <= inc(wr_ptr);
            if (do_pop | ow)  rd_ptr <= inc(rd_ptr);
         end
         count_q <= cnt_n;
         empty_q <= (cnt_n == '0);
         full_q  <= (cnt_n == CW'(BUF_SIZE));
         ovf_q   <= ovf_ev | (ovf_q & ~clr_err);
         udf_q   <= udf_ev | (udf_q & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok | ow) mem[wr_ptr] <= data_in;
   end

   always_comb begin
      data_out    = do_pop ? mem[rd_ptr] : '0;
      count       = count_q;
      attr_out    = '0;
      attr_out[0] = empty_q;
      attr_out[1] = full_q;
      attr_out[2] = ovf_q;
      attr_out[3] = udf_q;
   end

endmodule

// File: tb/tb_spi_ring_buffer.sv
// tb_spi_ring_buffer: directed checks of the ring FIFO at depth 4.
// Expected values are hand-computed per scenario.
module tb_spi_ring_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr;
   logic [31:0] data_in;
   logic        oe;
   logic [31:0] data_out;
   logic        flush;
   logic        clr_err;
   logic [2:0]  count;
   logic [3:0]  attr_out;

   int n_chk = 0;
   int n_bad = 0;

   spi_ring_buffer #(
      .DATA_WIDTH(32),
      .BUF_SIZE(4),
      .ATTR_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr(wr),
      .data_in(data_in),
      .oe(oe),
      .data_out(data_out),
      .flush(flush),
      .clr_err(clr_err),
      .count(count),
      .attr_out(attr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      wr = 1'b1;
      data_in = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [31:0] exp);
      oe = 1'b1;
      #1;
      chk(tag, data_out, exp);
      tick();
      oe = 1'b0;
   endtask

   task automatic clear();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wr = 1'b0;
      oe = 1'b0;
      flush = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      #12;
      chk("rst_attr", {28'd0, attr_out}, 32'h1);
      chk("rst_cnt", {29'd0, count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("idle_attr", {28'd0, attr_out}, 32'h1);

      pop("udf_data", 32'h0);
      chk("udf_attr", {28'd0, attr_out}, 32'h9);
      clear();
      chk("clr_udf", {28'd0, attr_out}, 32'h1);

      push(32'hA1);
      chk("cnt1", {29'd0, count}, 32'd1);
      chk("attr1", {28'd0, attr_out}, 32'h0);
      push(32'hA2);
      push(32'hA3);
      push(32'hA4);
      chk("full_cnt", {29'd0, count}, 32'd4);
      chk("full_attr", {28'd0, attr_out}, 32'h2);
      push(32'hA5);
      chk("ovf_attr", {28'd0, attr_out}, 32'h6);
      chk("ovf_cnt", {29'd0, count}, 32'd4);
`ifdef SPI_RING_BUFFER_OVERWRITE_EN
      pop("pop_a0", 32'hA2);
      pop("pop_a1", 32'hA3);
      pop("pop_a2", 32'hA4);
      pop("pop_a3", 32'hA5);
`else
      pop("pop_a0", 32'hA1);
      pop("pop_a1", 32'hA2);
      pop("pop_a2", 32'hA3);
      pop("pop_a3", 32'hA4);
`endif
      chk("drain_attr", {28'd0, attr_out}, 32'h5);
      clear();

      push(32'hD0);
      push(32'hD1);
      push(32'hD2);
      pop("pop_d0", 32'hD0);
      pop("pop_d1", 32'hD1);
      pop("pop_d2", 32'hD2);
      for (int i = 0; i < 4; i++) push(32'hB0 + i);
      chk("wrap_cnt", {29'd0, count}, 32'd4);
      for (int i = 0; i < 4; i++) pop("pop_b", 32'hB0 + i);
      chk("wrap_end_cnt", {29'd0, count}, 32'd0);
      chk("wrap_end_attr", {28'd0, attr_out}, 32'h1);

      for (int i = 0; i < 4; i++) push(32'hE0 + i);
      wr = 1'b1;
      oe = 1'b1;
      data_in = 32'hC0;
      #1;
      chk("both_full_data", data_out, 32'hE0);
      tick();
      wr = 1'b0;
      oe = 1'b0;
      chk("both_full_cnt", {29'd0, count}, 32'd4);
      chk("both_full_attr", {28'd0, attr_out}, 32'h2);
      pop("pop_e1", 32'hE1);
      pop("pop_e2", 32'hE2);
      pop("pop_e3", 32'hE3);
      pop("pop_c0", 32'hC0);

      push(32'hF0);
      push(32'hF1);
      chk("pre_flush_cnt", {29'd0, count}, 32'd2);
      flush = 1'b1;
      wr = 1'b1;
      data_in = 32'h99;
      tick();
      flush = 1'b0;
      wr = 1'b0;
      chk("flush_cnt", {29'd0, count}, 32'd0);
      chk("flush_attr", {28'd0, attr_out}, 32'h1);
      pop("flush_pop", 32'h0);
      chk("flush_udf", {28'd0, attr_out}, 32'h9);
      clear();

      wr = 1'b1;
      oe = 1'b1;
      data_in = 32'h55;
      #1;
      chk("both_empty_data", data_out, 32'h0);
      tick();
      wr = 1'b0;
      oe = 1'b0;
      chk("both_empty_cnt", {29'd0, count}, 32'd1);
      chk("both_empty_attr", {28'd0, attr_out}, 32'h8);
      pop("pop_55", 32'h55);
      clear();

      for (int i = 0; i < 4; i++) push(32'h60 + i);
      push(32'h64);
      chk("ovf2_attr", {28'd0, attr_out}, 32'h6);
      clear();
      chk("clr_ovf", {28'd0, attr_out}, 32'h2);
      clr_err = 1'b1;
      push(32'h65);
      clr_err = 1'b0;
      chk("clr_vs_set", {28'd0, attr_out}, 32'h6);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
